// File: rtl/pc_sequencer.sv
// PC register and instruction-fetch sequencer with a one-deep branch-target holder for the delay slot.
// Optional feature: define PC_ALIGN_CHECK_EN to add the sticky align_err output for misaligned targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tgt_addr,
    input  logic        tgt_valid,
    input  logic        instr_done,
    input  logic        fetch_waitrequest,
`ifdef PC_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    output logic        instr_fetched,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        in_delay_slot,
    output logic        active
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] holder;
    logic        pending;
    logic        misaligned;
    logic        running;

    assign running       = (state == S_FETCH) || (state == S_EXEC);
    assign fetch_req     = (state == S_FETCH);
    assign fetch_addr    = pc;
    assign instr_fetched = fetch_req & ~fetch_waitrequest;
    assign pc_plus4      = pc + 32'd4;
    assign in_delay_slot = pending & running;
    assign active        = running;

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = (holder[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A pending target always wins over a new tgt_valid in the delay slot; only a
    // holder-sourced load can halt, so falling through to HALT_ADDR keeps running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= RESET_VECTOR;
            holder  <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (!fetch_waitrequest) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (instr_done) begin
                        if (pending) begin
                            pending <= 1'b0;
                            if (misaligned) begin
                                state <= S_HALT;
                            end else begin
                                pc    <= holder;
                                state <= (holder == HALT_ADDR) ? S_HALT : S_FETCH;
                            end
                        end else begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                            if (tgt_valid) begin
                                holder  <= tgt_addr;
                                pending <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky until reset so software can see why the core stopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            align_err <= 1'b0;
        end else if ((state == S_EXEC) && instr_done && pending && misaligned) begin
            align_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a reference model predicts each fetch,
// a monitor checks every accepted fetch against the queued prediction.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] tgt_addr = '0;
    logic        tgt_valid = 1'b0;
    logic        instr_done = 1'b0;
    logic        fetch_waitrequest = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        instr_fetched;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_delay_slot;
    logic        active;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_err;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        dslot;
    } exp_t;

    exp_t        exp_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;

    // Reference model: architectural view only (current pc, pending target, halted).
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic        m_pending;
    logic        m_halted;
    logic        m_align;

    pc_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .HALT_ADDR(HALT_ADDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tgt_addr(tgt_addr),
        .tgt_valid(tgt_valid),
        .instr_done(instr_done),
        .fetch_waitrequest(fetch_waitrequest),
`ifdef PC_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .instr_fetched(instr_fetched),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .in_delay_slot(in_delay_slot),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule; pushes the fetch the core should perform next.
    task automatic model_step(input logic tv, input logic [31:0] tgt);
        exp_t e;
        if (m_pending) begin
            m_pending = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (m_target[1:0] != 2'b00) begin
                m_halted = 1'b1;
                m_align  = 1'b1;
            end else begin
                m_pc     = m_target;
                m_halted = (m_target == HALT_ADDR);
            end
`else
            m_pc     = m_target;
            m_halted = (m_target == HALT_ADDR);
`endif
        end else begin
            m_pc = m_pc + 32'd4;
            if (tv) begin
                m_pending = 1'b1;
                m_target  = tgt;
            end
        end
        if (!m_halted) begin
            e.addr  = m_pc;
            e.dslot = m_pending;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int cycles);
        exp_t e;
        reset             = 1'b0;
        instr_done        = 1'b0;
        tgt_valid         = 1'b0;
        fetch_waitrequest = 1'($urandom_range(0, 1));
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_output("rst_pc", pc, RESET_VECTOR);
            check_output("rst_fetch_req", 32'(fetch_req), 32'd0);
            check_output("rst_fetched", 32'(instr_fetched), 32'd0);
            check_output("rst_dslot", 32'(in_delay_slot), 32'd0);
            check_output("rst_active", 32'(active), 32'd0);
`ifdef PC_ALIGN_CHECK_EN
            check_output("rst_align_err", 32'(align_err), 32'd0);
`endif
        end
        exp_q.delete();
        reset             = 1'b1;
        fetch_waitrequest = 1'b0;
        m_pc      = RESET_VECTOR;
        m_pending = 1'b0;
        m_halted  = 1'b0;
        m_align   = 1'b0;
        @(negedge clk);
        check_output("idle_fetch_req", 32'(fetch_req), 32'd0);
        check_output("idle_active", 32'(active), 32'd0);
        @(posedge clk);
        #1;
        e.addr  = RESET_VECTOR;
        e.dslot = 1'b0;
        exp_q.push_back(e);
    endtask

    // One instruction: optional fetch stall (with ignored instr_done noise), fetch
    // acceptance, optional execute latency, then the completing instr_done.
    task automatic apply_stimulus(input int stall, input logic tv, input logic [31:0] tgt, input int exec_idle);
        for (int i = 0; i < stall; i++) begin
            fetch_waitrequest = 1'b1;
            instr_done        = 1'($urandom_range(0, 1));
            tgt_valid         = 1'($urandom_range(0, 1));
            tgt_addr          = $urandom;
            @(negedge clk);
            check_output("stall_fetch_req", 32'(fetch_req), 32'd1);
            check_output("stall_fetch_addr", fetch_addr, m_pc);
            check_output("stall_fetched", 32'(instr_fetched), 32'd0);
            check_output("stall_dslot", 32'(in_delay_slot), 32'(m_pending));
            @(posedge clk);
            #1;
        end
        fetch_waitrequest = 1'b0;
        instr_done        = 1'b0;
        tgt_valid         = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < exec_idle; i++) begin
            fetch_waitrequest = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_output("exec_fetch_req", 32'(fetch_req), 32'd0);
            check_output("exec_pc", pc, m_pc);
            @(posedge clk);
            #1;
        end
        instr_done = 1'b1;
        tgt_valid  = tv;
        tgt_addr   = tgt;
        model_step(tv, tgt);
        @(posedge clk);
        #1;
        instr_done        = 1'b0;
        tgt_valid         = 1'b0;
        fetch_waitrequest = 1'b0;
    endtask

    task automatic check_halted();
        for (int i = 0; i < 3; i++) begin
            instr_done = 1'(i != 1);
            tgt_valid  = 1'b1;
            tgt_addr   = $urandom & 32'hFFFFFFFC;
            @(negedge clk);
            check_output("halt_active", 32'(active), 32'd0);
            check_output("halt_fetch_req", 32'(fetch_req), 32'd0);
            check_output("halt_fetched", 32'(instr_fetched), 32'd0);
            check_output("halt_pc", pc, m_pc);
            check_output("halt_dslot", 32'(in_delay_slot), 32'd0);
`ifdef PC_ALIGN_CHECK_EN
            check_output("halt_align_err", 32'(align_err), 32'(m_align));
`endif
            @(posedge clk);
            #1;
        end
        instr_done = 1'b0;
        tgt_valid  = 1'b0;
    endtask

    // Monitor: every accepted fetch must match the oldest predicted fetch.
    always @(negedge clk) begin
        exp_t e;
        if (reset && instr_fetched) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_fetch: got fetch at %h expected no fetch", fetch_addr);
            end else begin
                e = exp_q.pop_front();
                check_output("fetch_addr", fetch_addr, e.addr);
                check_output("fetch_pc", pc, e.addr);
                check_output("fetch_pc_plus4", pc_plus4, e.addr + 32'd4);
                check_output("fetch_dslot", 32'(in_delay_slot), 32'(e.dslot));
                check_output("fetch_active", 32'(active), 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        int          sel;

        do_reset(3);
        // Sequential run, then branch with a delay slot that also asserts tgt_valid.
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(0, 1'b0, 32'h0, 1);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(0, 1'b1, 32'hBFC00100, 0);
        apply_stimulus(0, 1'b1, 32'h00001234, 2);
        apply_stimulus(5, 1'b0, 32'h0, 0);
        // Wrap from 0xFFFFFFFC to 0 by fall-through must not halt.
        apply_stimulus(0, 1'b1, 32'hFFFFFFF8, 0);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        apply_stimulus(1, 1'b0, 32'h0, 0);
        // Jump to HALT_ADDR halts once its delay slot completes.
        apply_stimulus(0, 1'b1, HALT_ADDR, 0);
        apply_stimulus(2, 1'b0, 32'h0, 0);
        check_halted();
        do_reset(1);

        for (int n = 0; n < 400; n++) begin
            if (m_halted) begin
                check_halted();
                do_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 29) == 0) begin
                fetch_waitrequest = 1'b1;
                @(posedge clk);
                #1;
                do_reset(1);
            end else begin
                sel = $urandom_range(0, 19);
                if (sel == 0)      tgt = HALT_ADDR;
                else if (sel == 1) tgt = 32'hFFFFFFF0;
                else               tgt = $urandom & 32'hFFFFFFFC;
                apply_stimulus($urandom_range(0, 3), 1'($urandom_range(0, 2) == 0), tgt,
                               $urandom_range(0, 2));
            end
        end

        // Misaligned target: halts under the alignment check, loads verbatim otherwise.
        if (m_halted) check_halted();
        do_reset(2);
        apply_stimulus(0, 1'b1, 32'hBFC00102, 0);
        apply_stimulus(0, 1'b0, 32'h0, 0);
        if (m_halted) begin
            check_output("misalign_pc_kept", m_pc, 32'hBFC00004);
            check_halted();
        end else begin
            check_output("misalign_pc_loaded", m_pc, 32'hBFC00102);
            apply_stimulus(0, 1'b0, 32'h0, 0);
            apply_stimulus(0, 1'b0, 32'h0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
